serial_subtractor: RTL

Bit-serial unsigned subtractor computing A − B one bit per clock, LSB first, with a single registered full-subtractor cell and a borrow flip-flop. It is the arithmetic counterpart of the combinational half-adder cell in the ALU library and sits beside it as the area-minimal difference unit. The handshake is start/busy/done, and the result is held until the next operation.

---
 rtl/serial_subtractor.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor. Computes (i_a - i_b) mod 2^WIDTH one bit
//   per clock, LSB first, through a single full-subtractor cell and a borrow
//   flip-flop. Start/busy/done handshake; the result is held until the next
//   operation completes.
//
// Parameters
//   WIDTH     operand/result width, 2..32
//
// Ports
//   i_clk     clock, rising edge
//   i_rst     asynchronous active-high reset; aborts and clears all outputs
//   i_start   request a subtraction (sampled only in IDLE)
//   i_a       minuend, captured on the accepting edge
//   i_b       subtrahend, captured on the accepting edge
//   o_busy    high whenever the block is not IDLE
//   o_done    one-cycle pulse when the result registers update
//   o_diff    (i_a - i_b) mod 2^WIDTH
//   o_borrow  final borrow, 1 iff i_a < i_b
//   o_zero    1 iff o_diff == 0
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] f_full_sub(input logic a, input logic b, input logic bi);
    logic d;
    logic bo;
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~a & bi) | (b & bi);
    return {bo, d};
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_shift_a;
  logic [WIDTH-1:0] r_shift_b;
  logic [WIDTH-1:0] r_diff_sr;
  logic             r_borrow;
  logic [CW-1:0]    r_count;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_zero;

  logic [1:0]       w_cell;
  logic [WIDTH-1:0] w_diff_next;

  // Current bit through the subtractor cell; new bit enters at the MSB so the
  // LSB of the result reaches bit 0 after WIDTH shifts.
  always_comb begin
    w_cell      = f_full_sub(r_shift_a[0], r_shift_b[0], r_borrow);
    w_diff_next = {w_cell[0], r_diff_sr[WIDTH-1:1]};
  end

  // Next-state and control decode.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_SHIFT;
          w_accept     = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_count == LAST_BIT) begin
          w_state_next = S_DONE;
          w_last       = 1'b1;
        end else begin
          w_state_next = S_SHIFT;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  // Operand shifters, partial difference, borrow and bit counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift_a <= {WIDTH{1'b0}};
      r_shift_b <= {WIDTH{1'b0}};
      r_diff_sr <= {WIDTH{1'b0}};
      r_borrow  <= 1'b0;
      r_count   <= {CW{1'b0}};
    end else if (w_accept) begin
      r_shift_a <= i_a;
      r_shift_b <= i_b;
      r_diff_sr <= {WIDTH{1'b0}};
      r_borrow  <= 1'b0;
      r_count   <= {CW{1'b0}};
    end else if (r_state == S_SHIFT) begin
      r_shift_a <= {1'b0, r_shift_a[WIDTH-1:1]};
      r_shift_b <= {1'b0, r_shift_b[WIDTH-1:1]};
      r_diff_sr <= w_diff_next;
      r_borrow  <= w_cell[1];
      // Park the counter at zero after the last bit instead of wrapping.
      r_count   <= w_last ? {CW{1'b0}} : (r_count + {{(CW-1){1'b0}}, 1'b1});
    end else begin
      r_shift_a <= r_shift_a;
      r_shift_b <= r_shift_b;
      r_diff_sr <= r_diff_sr;
      r_borrow  <= r_borrow;
      r_count   <= r_count;
    end
  end

  // Result registers: updated only on the last bit edge, held otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_done       <= 1'b0;
      r_diff       <= {WIDTH{1'b0}};
      r_borrow_out <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_diff       <= w_diff_next;
        r_borrow_out <= w_cell[1];
        r_zero       <= (w_diff_next == {WIDTH{1'b0}});
      end else begin
        r_diff       <= r_diff;
        r_borrow_out <= r_borrow_out;
        r_zero       <= r_zero;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_diff   = r_diff;
  assign o_borrow = r_borrow_out;
  assign o_zero   = r_zero;

endmodule
